// File: rtl/display_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : display_layer_sequencer
// Purpose  : Game-flow sequencer for the display pipeline. It tracks the game
//            state (idle, play, hit flash, level fade, game over) and the
//            remaining lives. It drives per-layer draw enables, a full-screen
//            colour override and a motion freeze for the moving objects.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock, rising edge
//   resetN       in   asynchronous active-low reset
//   startOfFrame in   one-cycle pulse per VGA frame
//   gameStart    in   one-cycle pulse from the key interface
//   playerHit    in   one-cycle pulse on ball/player collision
//   levelCleared in   one-cycle pulse when the last ball is popped
//   layerEnable  out  [3] present, [2] ball, [1] player, [0] rope
//   overrideEn   out  select overrideRGB instead of the layers
//   overrideRGB  out  RRRGGGBB full-screen colour
//   freezeMotion out  hold ball/player/rope movement
//   lives        out  remaining lives
//   state        out  IDLE=0 PLAY=1 HIT_FLASH=2 LEVEL_FADE=3 GAME_OVER=4
// ============================================================================
module display_layer_sequencer #(
  parameter int INIT_LIVES       = 3,
  parameter int FLASH_FRAMES     = 32,
  parameter int BLINK_FRAMES     = 4,
  parameter int FADE_STEP_FRAMES = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       gameStart,
  input  logic       playerHit,
  input  logic       levelCleared,
  output logic [3:0] layerEnable,
  output logic       overrideEn,
  output logic [7:0] overrideRGB,
  output logic       freezeMotion,
  output logic [1:0] lives,
  output logic [2:0] state
);

  localparam int FADE_FRAMES = 8 * FADE_STEP_FRAMES;
  localparam int MAX_FRAMES  = (FLASH_FRAMES > FADE_FRAMES) ? FLASH_FRAMES : FADE_FRAMES;
  // Counter is at least 6 bits and always wide enough to reach the longer phase.
  localparam int CNT_W       = ($clog2(MAX_FRAMES + 1) > 6) ? $clog2(MAX_FRAMES + 1) : 6;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] FLASH_END = CNT_W'(FLASH_FRAMES);
  localparam logic [CNT_W-1:0] FADE_END  = CNT_W'(FADE_FRAMES);
  localparam logic [CNT_W-1:0] BLINK_DIV = CNT_W'(BLINK_FRAMES);
  localparam logic [CNT_W-1:0] FADE_DIV  = CNT_W'(FADE_STEP_FRAMES);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PLAY       = 3'd1,
    ST_HIT_FLASH  = 3'd2,
    ST_LEVEL_FADE = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       nxt_lives;

  logic [3:0]       nxt_layer;
  logic             nxt_override_en;
  logic [7:0]       nxt_override_rgb;
  logic             nxt_freeze;
  logic [CNT_W-1:0] blink_phase;
  logic [CNT_W-1:0] fade_step;
  logic [2:0]       fade_k;
  logic [2:0]       fade_level;

  assign state   = cur_state;
  assign cnt_inc = (frame_cnt == CNT_MAX) ? frame_cnt : frame_cnt + 1'b1;

  // --------------------------------------------------------------------------
  // Next-state, next-count and next-lives logic. Every transition clears the
  // counter, so a startOfFrame coinciding with a transition is not counted in
  // the state being entered.
  // --------------------------------------------------------------------------
  always_comb begin
    nxt_state = cur_state;
    nxt_cnt   = frame_cnt;
    nxt_lives = lives;
    case (cur_state)
      ST_IDLE: begin
        if (gameStart) begin
          nxt_state = ST_PLAY;
          nxt_lives = 2'(INIT_LIVES);
          nxt_cnt   = '0;
        end
      end
      ST_PLAY: begin
        // A hit takes priority over a simultaneous level clear.
        if (playerHit) begin
          nxt_state = ST_HIT_FLASH;
          nxt_lives = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
          nxt_cnt   = '0;
        end else if (levelCleared) begin
          nxt_state = ST_LEVEL_FADE;
          nxt_cnt   = '0;
        end
      end
      ST_HIT_FLASH: begin
        // Player is invulnerable here: hits and clears are ignored.
        if (startOfFrame) begin
          if (cnt_inc >= FLASH_END) begin
            nxt_state = (lives == 2'd0) ? ST_GAME_OVER : ST_PLAY;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt_inc;
          end
        end
      end
      ST_LEVEL_FADE: begin
        if (startOfFrame) begin
          if (cnt_inc >= FADE_END) begin
            nxt_state = ST_PLAY;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt_inc;
          end
        end
      end
      ST_GAME_OVER: begin
        if (gameStart) begin
          nxt_state = ST_IDLE;
          nxt_cnt   = '0;
        end
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode. It is evaluated on the upcoming state/count so that the
  // registered outputs change in the same cycle as the state register.
  // --------------------------------------------------------------------------
  always_comb begin
    blink_phase      = nxt_cnt / BLINK_DIV;
    fade_step        = nxt_cnt / FADE_DIV;
    fade_k           = (fade_step > CNT_W'(7)) ? 3'd7 : fade_step[2:0];
    fade_level       = 3'd7 - fade_k;

    nxt_layer        = 4'b0000;
    nxt_override_en  = 1'b0;
    nxt_override_rgb = 8'h00;
    nxt_freeze       = 1'b1;
    case (nxt_state)
      ST_PLAY: begin
        nxt_layer  = 4'b1111;
        nxt_freeze = 1'b0;
      end
      ST_HIT_FLASH: begin
        // Player layer blinks: visible on even blink half-periods.
        nxt_layer = {2'b11, ~blink_phase[0], 1'b1};
      end
      ST_LEVEL_FADE: begin
        nxt_override_en  = 1'b1;
        nxt_override_rgb = {fade_level, fade_level, fade_level[2:1]};
      end
      ST_GAME_OVER: begin
        nxt_override_en  = 1'b1;
        nxt_override_rgb = 8'hE0;
      end
      default: begin
        nxt_layer        = 4'b0000;
        nxt_override_en  = 1'b0;
        nxt_override_rgb = 8'h00;
        nxt_freeze       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cur_state    <= ST_IDLE;
      frame_cnt    <= '0;
      lives        <= 2'd0;
      layerEnable  <= 4'b0000;
      overrideEn   <= 1'b0;
      overrideRGB  <= 8'h00;
      freezeMotion <= 1'b1;
    end else begin
      cur_state    <= nxt_state;
      frame_cnt    <= nxt_cnt;
      lives        <= nxt_lives;
      layerEnable  <= nxt_layer;
      overrideEn   <= nxt_override_en;
      overrideRGB  <= nxt_override_rgb;
      freezeMotion <= nxt_freeze;
    end
  end

endmodule
`default_nettype wire
